// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window feeder:
//   DW      - pixel / weight width (the convolution core is fixed at 8 bits)
//   KTAPS   - number of taps in a 3x3 kernel
//   win_t   - nine DW-bit values; index 0 = top-left, index 8 = bottom-right
//   cnt_w() - width of a counter that runs 0..n-1
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int DW    = 8;
  localparam int KTAPS = 9;

  typedef logic [KTAPS-1:0][DW-1:0] win_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
// Two-row delay line indexed by column. On each write the pixel previously
// stored one row back at this column moves to two rows back, and the new
// pixel is stored one row back.
//   clk    - clock
//   i_we   - write enable (one accepted pixel)
//   i_col  - column of the pixel being written
//   i_pix  - pixel being written
//   o_tap1 - pixel at this column from the previous row (r-1)
//   o_tap2 - pixel at this column from two rows back   (r-2)
// Taps are read combinationally at i_col, i.e. before the write lands.
// -----------------------------------------------------------------------------
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int PIX_W = DW,
  parameter int CW    = cnt_w(IMG_W)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [CW-1:0]    i_col,
  input  logic [PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0] o_tap1,
  output logic [PIX_W-1:0] o_tap2
);

  logic [PIX_W-1:0] r_row1 [IMG_W];
  logic [PIX_W-1:0] r_row2 [IMG_W];

  // NOTE: the row storage has no reset on purpose; the first two rows of
  // every frame never emit a window, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_row2[i_col] <= r_row1[i_col];
      r_row1[i_col] <= i_pix;
    end
  end

  assign o_tap1 = r_row1[i_col];
  assign o_tap2 = r_row2[i_col];

endmodule

// File: rtl/conv_window_feeder.sv
// -----------------------------------------------------------------------------
// conv_window_feeder
// Drives the convolution core's input interface from a serial weight stream
// and a raster pixel stream. Weights are collected into a shadow file and
// published (weight_valid pulse) only at a frame boundary; pixels are turned
// into 3x3 windows (no padding) with one in_valid pulse per window.
//   clk, rst_n                 - clock, synchronous active-low reset
//   wgt_in_valid/wgt_in_data   - serial weight bytes, W1..W9 row-major
//   pix_valid/pix_data         - raster pixels, row 0 col 0 first
//   pix_ready                  - pixel accepted when pix_valid && pix_ready
//   weight_valid, In_Weight_*  - kernel weights, held between pulses
//   in_valid, In_IFM_*         - window, 1 = top-left, 9 = bottom-right
//   frame_done                 - coincident with the last window of a frame
// -----------------------------------------------------------------------------
module conv_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wgt_in_valid,
  input  logic [DW-1:0] wgt_in_data,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          weight_valid,
  output logic [DW-1:0] In_Weight_1,
  output logic [DW-1:0] In_Weight_2,
  output logic [DW-1:0] In_Weight_3,
  output logic [DW-1:0] In_Weight_4,
  output logic [DW-1:0] In_Weight_5,
  output logic [DW-1:0] In_Weight_6,
  output logic [DW-1:0] In_Weight_7,
  output logic [DW-1:0] In_Weight_8,
  output logic [DW-1:0] In_Weight_9,
  output logic          in_valid,
  output logic [DW-1:0] In_IFM_1,
  output logic [DW-1:0] In_IFM_2,
  output logic [DW-1:0] In_IFM_3,
  output logic [DW-1:0] In_IFM_4,
  output logic [DW-1:0] In_IFM_5,
  output logic [DW-1:0] In_IFM_6,
  output logic [DW-1:0] In_IFM_7,
  output logic [DW-1:0] In_IFM_8,
  output logic [DW-1:0] In_IFM_9,
  output logic          frame_done
);

  import conv_pkg::*;

  localparam int CW  = cnt_w(IMG_W);
  localparam int RW  = cnt_w(IMG_H);
  localparam int WCW = cnt_w(KTAPS);

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [WCW-1:0] WGT_LAST = WCW'(KTAPS - 1);

  // Weight collector state
  logic [WCW-1:0] r_wcnt;
  win_t           r_shadow;
  win_t           r_wgt;
  logic           r_wgt_pending;
  logic           r_weights_loaded;
  logic           r_weight_valid;

  // Raster position of the next pixel to be accepted
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Two most recent window columns; index 2 = top (r-2), 0 = bottom (r)
  logic [2:0][DW-1:0] r_col_old;
  logic [2:0][DW-1:0] r_col_new;

  // Window output
  win_t r_ifm;
  logic r_in_valid;
  logic r_frame_done;

  logic [DW-1:0] w_lb1;
  logic [DW-1:0] w_lb2;
  logic          w_boundary;
  logic          w_frame_idle;
  logic          w_pix_ready;
  logic          w_accept;
  logic          w_win_hit;
  logic          w_last_pix;

  // A pending reload stalls pixels as soon as the raster wraps, so no pixel of
  // the next frame slips in under the old weights; the copy itself waits until
  // the last window has also left, keeping weight_valid and in_valid apart.
  assign w_boundary   = (r_col == '0) && (r_row == '0);
  assign w_frame_idle = w_boundary && !r_in_valid;
  assign w_pix_ready  = r_weights_loaded && !(r_wgt_pending && w_boundary);
  assign w_accept     = pix_valid && w_pix_ready;
  assign w_win_hit    = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_last_pix   = (r_row == ROW_LAST) && (r_col == COL_LAST);

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (DW),
    .CW    (CW)
  ) u_line_buffer (
    .clk    (clk),
    .i_we   (w_accept),
    .i_col  (r_col),
    .i_pix  (pix_data),
    .o_tap1 (w_lb1),
    .o_tap2 (w_lb2)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt           <= '0;
      r_shadow         <= '0;
      r_wgt            <= '0;
      r_wgt_pending    <= 1'b0;
      r_weights_loaded <= 1'b0;
      r_weight_valid   <= 1'b0;
      r_col            <= '0;
      r_row            <= '0;
      r_col_old        <= '0;
      r_col_new        <= '0;
      r_ifm            <= '0;
      r_in_valid       <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_weight_valid <= 1'b0;
      r_in_valid     <= 1'b0;
      r_frame_done   <= 1'b0;

      // Weight collection; bytes arriving while a reload is pending are dropped
      if (r_wgt_pending && w_frame_idle) begin
        r_wgt            <= r_shadow;
        r_weight_valid   <= 1'b1;
        r_weights_loaded <= 1'b1;
        r_wgt_pending    <= 1'b0;
      end else if (wgt_in_valid && !r_wgt_pending) begin
        r_shadow[r_wcnt] <= wgt_in_data;
        if (r_wcnt == WGT_LAST) begin
          r_wcnt        <= '0;
          r_wgt_pending <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end

      if (w_accept) begin
        // Raster position
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end

        // The shifter runs across row wraps; windows at c<2 are just not emitted
        r_col_old <= r_col_new;
        r_col_new <= {w_lb2, w_lb1, pix_data};

        if (w_win_hit) begin
          r_ifm        <= {pix_data,     r_col_new[0], r_col_old[0],
                           w_lb1,        r_col_new[1], r_col_old[1],
                           w_lb2,        r_col_new[2], r_col_old[2]};
          r_in_valid   <= 1'b1;
          r_frame_done <= w_last_pix;
        end
      end
    end
  end

  assign pix_ready    = w_pix_ready;
  assign weight_valid = r_weight_valid;
  assign in_valid     = r_in_valid;
  assign frame_done   = r_frame_done;

  assign In_Weight_1 = r_wgt[0];
  assign In_Weight_2 = r_wgt[1];
  assign In_Weight_3 = r_wgt[2];
  assign In_Weight_4 = r_wgt[3];
  assign In_Weight_5 = r_wgt[4];
  assign In_Weight_6 = r_wgt[5];
  assign In_Weight_7 = r_wgt[6];
  assign In_Weight_8 = r_wgt[7];
  assign In_Weight_9 = r_wgt[8];

  assign In_IFM_1 = r_ifm[0];
  assign In_IFM_2 = r_ifm[1];
  assign In_IFM_3 = r_ifm[2];
  assign In_IFM_4 = r_ifm[3];
  assign In_IFM_5 = r_ifm[4];
  assign In_IFM_6 = r_ifm[5];
  assign In_IFM_7 = r_ifm[6];
  assign In_IFM_8 = r_ifm[7];
  assign In_IFM_9 = r_ifm[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_conv_window_feeder
// Self-checking bench for conv_window_feeder (8x8 frames). A negedge monitor
// keeps a reference image of accepted pixels, pushes the expected window for
// every accept into a queue and pops/compares it when in_valid appears.
// Expected weight sets are queued when their bytes are sent.
// -----------------------------------------------------------------------------
module tb_conv_window_feeder;

  localparam int W = 8;
  localparam int H = 8;

  typedef logic [8:0][7:0] vec9_t;
  typedef struct packed {
    vec9_t p;
    logic  fd;
    int    cyc;
  } exp_win_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wgt_in_valid = 1'b0;
  logic [7:0] wgt_in_data = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;

  wire             pix_ready;
  wire             weight_valid;
  wire             in_valid;
  wire             frame_done;
  wire [8:0][7:0]  wgt_bus;
  wire [8:0][7:0]  ifm_bus;

  conv_window_feeder #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wgt_in_valid (wgt_in_valid),
    .wgt_in_data  (wgt_in_data),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .weight_valid (weight_valid),
    .In_Weight_1  (wgt_bus[0]),
    .In_Weight_2  (wgt_bus[1]),
    .In_Weight_3  (wgt_bus[2]),
    .In_Weight_4  (wgt_bus[3]),
    .In_Weight_5  (wgt_bus[4]),
    .In_Weight_6  (wgt_bus[5]),
    .In_Weight_7  (wgt_bus[6]),
    .In_Weight_8  (wgt_bus[7]),
    .In_Weight_9  (wgt_bus[8]),
    .in_valid     (in_valid),
    .In_IFM_1     (ifm_bus[0]),
    .In_IFM_2     (ifm_bus[1]),
    .In_IFM_3     (ifm_bus[2]),
    .In_IFM_4     (ifm_bus[3]),
    .In_IFM_5     (ifm_bus[4]),
    .In_IFM_6     (ifm_bus[5]),
    .In_IFM_7     (ifm_bus[6]),
    .In_IFM_8     (ifm_bus[7]),
    .In_IFM_9     (ifm_bus[8]),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  exp_win_t   exp_q[$];
  vec9_t      wq[$];
  logic [7:0] img [H][W];
  int         m_row = 0;
  int         m_col = 0;
  vec9_t      m_active = '0;
  int         n_win = 0, n_fd = 0, n_wv = 0, n_accept = 0;
  int         m_acc_at_wv = 0, m_win_at_wv = 0, m_fd_at_wv = 0;
  logic       m_first_seen = 1'b0;
  vec9_t      m_first = '0;
  vec9_t      m_last = '0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_window: in_valid=1 at cycle %0d with no accepted window pixel", cyc);
        end else begin
          exp_win_t e;
          e = exp_q.pop_front();
          n_checks++;
          if (e.cyc + 1 != cyc) begin
            n_fail++;
            $display("FAIL window_latency: window at cycle %0d, want cycle %0d", cyc, e.cyc + 1);
          end
          n_checks++;
          if (ifm_bus !== e.p) begin
            n_fail++;
            $display("FAIL window_data: got %h want %h", ifm_bus, e.p);
          end
          n_checks++;
          if (frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL frame_done: got %b want %b", frame_done, e.fd);
          end
          n_checks++;
          if (wgt_bus !== m_active) begin
            n_fail++;
            $display("FAIL window_weights: got %h want %h", wgt_bus, m_active);
          end
        end
        if (!m_first_seen) begin
          m_first_seen = 1'b1;
          m_first = ifm_bus;
        end
        m_last = ifm_bus;
        n_win++;
        if (frame_done) n_fd++;
      end else if (frame_done) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_done_alone: frame_done=1 with in_valid=0 at cycle %0d", cyc);
      end

      if (weight_valid) begin
        n_checks++;
        if (in_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL wv_iv_overlap: weight_valid and in_valid both 1 at cycle %0d", cyc);
        end
        n_checks++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_weight_valid: got pulse with no weight set sent");
        end else begin
          vec9_t ew;
          ew = wq.pop_front();
          n_checks++;
          if (wgt_bus !== ew) begin
            n_fail++;
            $display("FAIL weights: got %h want %h", wgt_bus, ew);
          end
          m_active = ew;
        end
        n_wv++;
        m_acc_at_wv = n_accept;
        m_win_at_wv = n_win;
        m_fd_at_wv  = n_fd;
      end

      if (pix_valid && pix_ready) begin
        img[m_row][m_col] = pix_data;
        if (m_row >= 2 && m_col >= 2) begin
          exp_win_t e;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              e.p[3*dr+dc] = img[m_row-2+dr][m_col-2+dc];
          e.fd  = (m_row == H-1) && (m_col == W-1);
          e.cyc = cyc;
          exp_q.push_back(e);
        end
        n_accept++;
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row == H-1) ? 0 : m_row + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wq.delete();
    m_row    = 0;
    m_col    = 0;
    m_active = '0;
  endtask

  task automatic send_weights(input int base);
    vec9_t v;
    for (int k = 0; k < 9; k++) v[k] = 8'(base + k);
    wq.push_back(v);
    for (int k = 0; k < 9; k++) begin
      wgt_in_valid = 1'b1;
      wgt_in_data  = 8'(base + k);
      @(posedge clk);
      #1;
    end
    wgt_in_valid = 1'b0;
  endtask

  task automatic wait_wv(input int start);
    for (int t = 0; t < 100 && n_wv == start; t++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (n_wv == start) begin
      n_fail++;
      $display("FAIL weight_valid_timeout: got no pulse within 100 cycles, want one");
    end
  endtask

  // Offers npix raster pixels (value base+k); gap_pct inserts random idle cycles.
  task automatic stream(input int npix, input int base, input int gap_pct, output int stalls);
    logic acc;
    stalls = 0;
    for (int k = 0; k < npix; k++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      pix_valid = 1'b1;
      pix_data  = 8'(base + k);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = pix_ready;
        if (!acc) stalls++;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL pixel_timeout: pixel %0d got no pix_ready within 200 cycles", k);
        pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
  endtask

  function automatic vec9_t raster_window(input int r, input int c);
    vec9_t v;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v[3*dr+dc] = 8'(W*(r-2+dr) + c-2+dc);
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({pix_ready, weight_valid, in_valid, frame_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL %s_strobes: got ready/wv/iv/fd=%b want 0000", tag,
               {pix_ready, weight_valid, in_valid, frame_done});
    end
    n_checks++;
    if (wgt_bus !== '0) begin
      n_fail++;
      $display("FAIL %s_weights: got %h want 0", tag, wgt_bus);
    end
    n_checks++;
    if (ifm_bus !== '0) begin
      n_fail++;
      $display("FAIL %s_ifm: got %h want 0", tag, ifm_bus);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_frame();
    int ready_cnt = 0;
    int st, w0, f0;
    pix_valid = 1'b1;
    pix_data  = 8'd0;
    repeat (10) begin
      @(negedge clk);
      if (pix_ready) ready_cnt++;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    n_checks++;
    if (ready_cnt != 0 || n_accept != 0 || n_win != 0) begin
      n_fail++;
      $display("FAIL no_weights_ready: got ready_cycles=%0d accepts=%0d windows=%0d want 0/0/0",
               ready_cnt, n_accept, n_win);
    end
    send_weights(1);
    wait_wv(0);
    n_checks++;
    if (m_acc_at_wv != 0) begin
      n_fail++;
      $display("FAIL wv_before_pixels: got %0d accepts before weight_valid, want 0", m_acc_at_wv);
    end
    w0 = n_win;
    f0 = n_fd;
    m_first_seen = 1'b0;
    stream(64, 0, 0, st);
    idle(3);
    n_checks++;
    if (m_first !== raster_window(2, 2)) begin
      n_fail++;
      $display("FAIL first_window: got %h want %h", m_first, raster_window(2, 2));
    end
    n_checks++;
    if (n_win - w0 != 36 || n_fd - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_count: got windows=%0d frame_done=%0d want 36/1", n_win - w0, n_fd - f0);
    end
    n_checks++;
    if (m_last[8] !== 8'd63) begin
      n_fail++;
      $display("FAIL last_window: got IFM_9=%0d want 63", m_last[8]);
    end
  endtask

  task automatic test_reload();
    int st, st2, w0, f0, wv0, a0;
    w0  = n_win;
    f0  = n_fd;
    wv0 = n_wv;
    a0  = n_accept;
    fork
      stream(64, 0, 0, st);
      begin
        for (int t = 0; t < 500 && m_row != 4; t++) begin
          @(posedge clk);
          #1;
        end
        send_weights(10);
      end
    join
    stream(64, 0, 0, st2);
    idle(3);
    n_checks++;
    if (n_wv != wv0 + 1) begin
      n_fail++;
      $display("FAIL reload_pulses: got %0d weight_valid pulses want 1", n_wv - wv0);
    end
    n_checks++;
    if (m_win_at_wv - w0 != 36 || m_fd_at_wv - f0 != 1) begin
      n_fail++;
      $display("FAIL reload_order: before weight_valid got windows=%0d frame_done=%0d want 36/1",
               m_win_at_wv - w0, m_fd_at_wv - f0);
    end
    n_checks++;
    if (m_acc_at_wv != a0 + 64) begin
      n_fail++;
      $display("FAIL reload_boundary: got %0d accepts before weight_valid want %0d",
               m_acc_at_wv - a0, 64);
    end
    n_checks++;
    if (n_win - w0 != 72 || n_fd - f0 != 2) begin
      n_fail++;
      $display("FAIL reload_frames: got windows=%0d frame_done=%0d want 72/2", n_win - w0, n_fd - f0);
    end
  endtask

  task automatic test_gaps();
    int st, w0, f0, a0;
    w0 = n_win;
    f0 = n_fd;
    a0 = n_accept;
    m_first_seen = 1'b0;
    stream(64, 0, 50, st);
    idle(3);
    n_checks++;
    if (n_win - w0 != 36 || n_fd - f0 != 1 || n_accept - a0 != 64) begin
      n_fail++;
      $display("FAIL gaps_count: got windows=%0d frame_done=%0d accepts=%0d want 36/1/64",
               n_win - w0, n_fd - f0, n_accept - a0);
    end
    n_checks++;
    if (m_first !== raster_window(2, 2) || m_last !== raster_window(7, 7)) begin
      n_fail++;
      $display("FAIL gaps_windows: got first=%h last=%h want %h %h", m_first, m_last,
               raster_window(2, 2), raster_window(7, 7));
    end
  endtask

  task automatic test_reset_mid();
    int st, w0;
    stream(3*W + 4, 0, 0, st);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (pix_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got pix_ready=%b want 0 before weights", pix_ready);
    end
    @(posedge clk);
    #1;
    send_weights(1);
    wait_wv(n_wv);
    w0 = n_win;
    m_first_seen = 1'b0;
    stream(64, 0, 0, st);
    idle(3);
    n_checks++;
    if (m_first !== raster_window(2, 2) || n_win - w0 != 36) begin
      n_fail++;
      $display("FAIL mid_reset_frame: got first=%h windows=%0d want %h 36", m_first, n_win - w0,
               raster_window(2, 2));
    end
  endtask

  task automatic test_back_to_back();
    int st, w0, f0;
    w0 = n_win;
    f0 = n_fd;
    stream(2*W*H, 0, 0, st);
    idle(3);
    n_checks++;
    if (st != 0) begin
      n_fail++;
      $display("FAIL b2b_ready: got %0d cycles with pix_ready=0 want 0", st);
    end
    n_checks++;
    if (n_win - w0 != 72 || n_fd - f0 != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got windows=%0d frame_done=%0d want 72/2", n_win - w0, n_fd - f0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_reload();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    idle(5);
    n_checks++;
    if (exp_q.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d windows and %0d weight sets outstanding want 0/0",
               exp_q.size(), wq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
